// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative multiply/divide unit holding the HI/LO pair.
// Handles MULTU/MULT (shift-add) and DIVU/DIV (restoring division), one
// iteration per clock for N clocks. It also handles MTHI/MTLO writes.
// Optional signed support is built when the macro MULDIV_SIGNED_EN is defined.
// Signed ops run on magnitudes and then pass through a one-cycle FIX state
// that restores the signs. Without the macro, op[0] is ignored and every op
// is unsigned.
module muldiv_hilo_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] rs_data,
  input  logic [N-1:0] rt_data,
  input  logic         mthi,
  input  logic         mtlo,
  input  logic [N-1:0] wr_data,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef MULDIV_SIGNED_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    DONE = 3'd4
  } state_t;
`endif

  state_t         state;
  logic [CW-1:0]  cnt;
  // acc_hi: upper product half / partial remainder.
  // acc_lo: multiplier being shifted out / dividend shifting into the quotient.
  logic [N-1:0]   acc_hi;
  logic [N-1:0]   acc_lo;
  // opb: multiplicand / divisor.
  logic [N-1:0]   opb;

  logic [N:0]     mul_sum;
  logic [N:0]     div_shift;
  logic [N:0]     div_diff;
  logic           div_ok;

  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic           move_ok;
  logic           iter_last;

`ifdef MULDIV_SIGNED_EN
  logic           fix_en;    // op was signed, route through FIX
  logic           is_div;    // FIX applies divide rules rather than product rule
  logic           neg_main;  // negate product / quotient
  logic           neg_rem;   // remainder takes the dividend's (negative) sign
  logic [2*N-1:0] prod_neg;
  logic [N-1:0]   fix_hi;
  logic [N-1:0]   fix_lo;
`else
  logic           unused_op0;
  assign unused_op0 = op[0];
`endif

  assign iter_last = (cnt == CNT_LAST);
  // Moves are only honoured while no op owns HI/LO; in IDLE a start takes priority.
  assign move_ok   = (state == DONE) || ((state == IDLE) && !start);

  // One shift-add step and one restoring-division step, evaluated every cycle.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(N+1){1'b0}});
    div_shift = {acc_hi, acc_lo[N-1]};
    div_diff  = div_shift - {1'b0, opb};
    div_ok    = ~div_diff[N];
  end

  // Operand conditioning at launch: magnitudes for signed ops, raw values otherwise.
  always_comb begin
    a_mag = rs_data;
    b_mag = rt_data;
`ifdef MULDIV_SIGNED_EN
    if (op[0]) begin
      if (rs_data[N-1]) a_mag = -rs_data;
      if (rt_data[N-1]) b_mag = -rt_data;
    end
`endif
  end

`ifdef MULDIV_SIGNED_EN
  // Sign restoration applied on the FIX->DONE edge. A zero divisor keeps
  // the all-ones quotient, and the remainder sign fix returns the dividend.
  always_comb begin
    prod_neg = -{acc_hi, acc_lo};
    fix_hi   = acc_hi;
    fix_lo   = acc_lo;
    if (is_div) begin
      if (neg_main) fix_lo = -acc_lo;
      if (neg_rem)  fix_hi = -acc_hi;
    end else if (neg_main) begin
      fix_hi = prod_neg[2*N-1:N];
      fix_lo = prod_neg[N-1:0];
    end
  end
`endif

  // Control FSM, iteration datapath and HI/LO registers with registered busy/done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opb      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef MULDIV_SIGNED_EN
      fix_en   <= 1'b0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      if (move_ok) begin
        if (mthi) hi <= wr_data;
        if (mtlo) lo <= wr_data;
      end

      case (state)
        IDLE: begin
          if (start) begin
            acc_hi <= '0;
            acc_lo <= a_mag;
            opb    <= b_mag;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= op[1] ? DIV : MUL;
`ifdef MULDIV_SIGNED_EN
            fix_en   <= op[0];
            is_div   <= op[1];
            neg_main <= op[0] && (rs_data[N-1] ^ rt_data[N-1]) && (!op[1] || (|rt_data));
            neg_rem  <= op[0] && rs_data[N-1];
`endif
          end
        end

        MUL, DIV: begin
          if (!iter_last) begin
            cnt <= cnt + CNT_ONE;
            if (state == MUL) begin
              acc_hi <= mul_sum[N:1];
              acc_lo <= {mul_sum[0], acc_lo[N-1:1]};
            end else begin
              acc_hi <= div_ok ? div_diff[N-1:0] : div_shift[N-1:0];
              acc_lo <= {acc_lo[N-2:0], div_ok};
            end
          end else begin
`ifdef MULDIV_SIGNED_EN
            if (fix_en) begin
              state <= FIX;
            end else begin
              hi    <= acc_hi;
              lo    <= acc_lo;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
`else
            hi    <= acc_hi;
            lo    <= acc_lo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`endif
          end
        end

`ifdef MULDIV_SIGNED_EN
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
`endif

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed testbench for muldiv_hilo_unit (N=32). Expected values are hand
// computed. When MULDIV_SIGNED_EN is defined, the signed expectations apply.
module tb_muldiv_hilo_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

`ifdef MULDIV_SIGNED_EN
  localparam bit SGN  = 1'b1;
  localparam int SLAT = 34;
`else
  localparam bit SGN  = 1'b0;
  localparam int SLAT = 33;
`endif

  muldiv_hilo_unit #(.N(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // poke: 0 none, 1 start mid-op, 2 mtlo mid-op, 3 mthi together with start
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int elat, input int poke);
    int lat;
    int busy_n;
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    if (poke == 3) begin
      mthi    = 1'b1;
      wr_data = 32'hDEAD_0001;
    end
    tick;
    start = 1'b0;
    mthi  = 1'b0;
    chk({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
    chk({tag, "_hold_hi"}, hi, m_hi);
    chk({tag, "_hold_lo"}, lo, m_lo);
    lat    = 0;
    busy_n = 1;
    while (done !== 1'b1 && lat < 60) begin
      if (poke == 1 && lat == 5) begin
        start   = 1'b1;
        op      = 2'b00;
        rs_data = 32'd3;
        rt_data = 32'd3;
      end
      if (poke == 2 && lat == 3) begin
        mtlo    = 1'b1;
        wr_data = 32'h0000_0055;
      end
      tick;
      start = 1'b0;
      mtlo  = 1'b0;
      lat++;
      if (busy === 1'b1) busy_n++;
      if (poke == 2 && lat == 4) chk({tag, "_mtlo_busy"}, lo, m_lo);
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_busy_cycles"}, busy_n, elat);
    chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    m_hi = ehi;
    m_lo = elo;
    $display("op=%0d rs=0x%08h rt=0x%08h hi=0x%08h lo=0x%08h latency=%0d", o, a, b, hi, lo, lat);
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    rs_data = '0;
    rt_data = '0;
    mthi    = 1'b0;
    mtlo    = 1'b0;
    wr_data = '0;
    m_hi    = '0;
    m_lo    = '0;

    // Reset state
    #22;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick;

    // MULTU max*max, with an MTHI presented alongside start (start wins)
    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 3);
    tick;
    chk("multu_max_done_pulse", {31'd0, done}, 32'd0);
    chk("multu_max_idle_busy", {31'd0, busy}, 32'd0);

    // DIVU 100/7 with an ignored start mid-op
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("divu_single_done", {31'd0, done}, 32'd0);
      chk("divu_no_queue_busy", {31'd0, busy}, 32'd0);
    end

    // DIVU by zero, with an MTLO presented while busy
    run_op("divu_by0", 2'b10, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 33, 2);
    tick;

    // MULT -3*5, then MTHI during the DONE cycle
    run_op("mult_m3_5", 2'b01, 32'hFFFF_FFFD, 32'd5,
           SGN ? 32'hFFFF_FFFF : 32'h0000_0004, 32'hFFFF_FFF1, SLAT, 0);
    mthi    = 1'b1;
    wr_data = 32'h1357_9BDF;
    tick;
    mthi = 1'b0;
    chk("mthi_in_done_hi", hi, 32'h1357_9BDF);
    chk("mthi_in_done_lo", lo, m_lo);
    m_hi = 32'h1357_9BDF;

    // MTHI while idle, then MTHI+MTLO together
    mthi    = 1'b1;
    wr_data = 32'hA5A5_A5A5;
    tick;
    mthi = 1'b0;
    chk("mthi_idle_hi", hi, 32'hA5A5_A5A5);
    chk("mthi_idle_lo", lo, m_lo);
    mthi    = 1'b1;
    mtlo    = 1'b1;
    wr_data = 32'h0F0F_0F0F;
    tick;
    mthi = 1'b0;
    mtlo = 1'b0;
    chk("mt_both_hi", hi, 32'h0F0F_0F0F);
    chk("mt_both_lo", lo, 32'h0F0F_0F0F);
    m_hi = 32'h0F0F_0F0F;
    m_lo = 32'h0F0F_0F0F;

    // Signed divide corner cases (unsigned interpretation without the macro)
    run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2,
           SGN ? 32'hFFFF_FFFF : 32'h0000_0001, SGN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC, SLAT, 0);
    tick;
    run_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
           SGN ? 32'h0000_0000 : 32'h8000_0000, SGN ? 32'h8000_0000 : 32'h0000_0000, SLAT, 0);
    tick;
    run_op("div_m5_by0", 2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, SLAT, 0);
    tick;
    run_op("multu_2p32", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 33, 0);
    tick;

    // Reset asserted at iteration 10 of a MULTU
    start   = 1'b1;
    op      = 2'b00;
    rs_data = 32'h1234_5678;
    rt_data = 32'd3;
    tick;
    start = 1'b0;
    repeat (10) tick;
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    tick;
    chk("midrst_after_busy", {31'd0, busy}, 32'd0);
    run_op("multu_7_6", 2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 33, 0);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
